// File: rtl/arm_pkg.sv
// arm_pkg
// Shared definitions for the multi-cycle ARM controller.
//   - COND_EQ .. COND_NV : 4-bit condition-field encodings (Instr[31:28])
//   - FLAG_N/Z/C/V       : bit positions of each flag inside {N,Z,C,V}
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// condcheck
// Purely combinational evaluation of an ARM condition field against the
// current {N,Z,C,V} flags.
// Ports:
//   cond_i        in  4 : condition field
//   flags_i       in  4 : current {N,Z,C,V}
//   condExNext_o  out 1 : 1 when the instruction should execute
// Configuration macro: CONDLOGIC_NV_ALWAYS_EN
//   defined   -> condition 1111 executes unconditionally
//   undefined -> condition 1111 never executes (default)
module condcheck
    import arm_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condExNext_o
);

    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;
    logic signedGe;

    assign flagN    = flags_i[FLAG_N];
    assign flagZ    = flags_i[FLAG_Z];
    assign flagC    = flags_i[FLAG_C];
    assign flagV    = flags_i[FLAG_V];
    assign signedGe = (flagN == flagV);

    // Decode the condition field into a single execute decision. The
    // signed comparisons all reduce to N==V, so that term is shared.
    always_comb begin
        condExNext_o = 1'b0;
        case (cond_i)
            COND_EQ: condExNext_o = flagZ;
            COND_NE: condExNext_o = ~flagZ;
            COND_CS: condExNext_o = flagC;
            COND_CC: condExNext_o = ~flagC;
            COND_MI: condExNext_o = flagN;
            COND_PL: condExNext_o = ~flagN;
            COND_VS: condExNext_o = flagV;
            COND_VC: condExNext_o = ~flagV;
            COND_HI: condExNext_o = flagC & ~flagZ;
            COND_LS: condExNext_o = ~flagC | flagZ;
            COND_GE: condExNext_o = signedGe;
            COND_LT: condExNext_o = ~signedGe;
            COND_GT: condExNext_o = ~flagZ & signedGe;
            COND_LE: condExNext_o = flagZ | ~signedGe;
            COND_AL: condExNext_o = 1'b1;
`ifdef CONDLOGIC_NV_ALWAYS_EN
            COND_NV: condExNext_o = 1'b1;
`else
            COND_NV: condExNext_o = 1'b0;
`endif
            default: condExNext_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// condlogic
// Conditional-execution stage of the multi-cycle ARM controller. Holds the
// NZCV flags, captures the condition result once per instruction during the
// Decode cycle, and gates decode's raw write requests.
// Ports:
//   clk, reset  in  1 : clock, synchronous active-high reset
//   Cond        in  4 : Instr[31:28]
//   ALUFlags    in  4 : {N,Z,C,V} from the ALU
//   FlagW       in  2 : [1] write N,Z  [0] write C,V
//   PCS, NextPC, RegW, MemW, IRWrite in 1 : raw requests from decode
//   PCWrite, RegWrite, MemWrite out 1 : committed write enables
//   Flags       out 4 : current {N,Z,C,V}
//   CondEx      out 1 : registered condition result
// Configuration macro: CONDLOGIC_NV_ALWAYS_EN (see condcheck)
module condlogic
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [1:0] flagsNZ_q;
    logic [1:0] flagsNZ_d;
    logic [1:0] flagsCV_q;
    logic [1:0] flagsCV_d;
    logic       condEx_q;
    logic       condEx_d;
    logic       decCyc_q;
    logic       condExNext;

    assign Flags = {flagsNZ_q, flagsCV_q};

    condcheck uCondcheck (
        .cond_i       (Cond),
        .flags_i      (Flags),
        .condExNext_o (condExNext)
    );

    // Next-state logic. CondEx only reloads at the end of the Decode cycle so
    // it stays put through the rest of the instruction. The flag halves are
    // gated by the registered CondEx, which means a capture and a flag write
    // in the same edge evaluate on the old flags.
    always_comb begin
        condEx_d  = condEx_q;
        flagsNZ_d = flagsNZ_q;
        flagsCV_d = flagsCV_q;
        if (decCyc_q) begin
            condEx_d = condExNext;
        end
        if (FlagW[1] && condEx_q) begin
            flagsNZ_d = ALUFlags[FLAG_N:FLAG_Z];
        end
        if (FlagW[0] && condEx_q) begin
            flagsCV_d = ALUFlags[FLAG_C:FLAG_V];
        end
    end

    // State registers. Reset clears everything together, which also
    // suppresses any in-flight write until the next Decode capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            flagsNZ_q <= 2'b00;
            flagsCV_q <= 2'b00;
            condEx_q  <= 1'b0;
            decCyc_q  <= 1'b0;
        end else begin
            flagsNZ_q <= flagsNZ_d;
            flagsCV_q <= flagsCV_d;
            condEx_q  <= condEx_d;
            decCyc_q  <= IRWrite;
        end
    end

    // Committed enables. NextPC is the fetch increment and is never gated.
    always_comb begin
        RegWrite = RegW & condEx_q;
        MemWrite = MemW & condEx_q;
        PCWrite  = (PCS & condEx_q) | NextPC;
    end

    assign CondEx = condEx_q;

endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic
// Directed self-checking bench for condlogic. Inputs change 1 time unit
// after the rising edge and outputs are sampled there as well.
module tb_condlogic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    int passCount = 0;
    int checkCount = 0;

    condlogic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every decode-side input at once.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic pcs,
                                 input logic npc, input logic rw,
                                 input logic mw, input logic irw);
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        NextPC   = npc;
        RegW     = rw;
        MemW     = mw;
        IRWrite  = irw;
    endtask

    // Fetch then Decode for an instruction with condition c; afterwards the
    // bench sits at the first Execute cycle with CondEx freshly captured.
    task automatic fetchDecode(input logic [3:0] c);
        applyStimulus(c, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(c, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // Full instruction whose Execute cycle writes flags.
    task automatic aluInstr(input logic [3:0] c, input logic [1:0] fw,
                            input logic [3:0] alu);
        fetchDecode(c);
        applyStimulus(c, alu, fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(c, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        aluInstr(4'b1110, 2'b11, 4'b1111);
        checkCount++;
        if (Flags !== 4'b1111) $display("[TB] FAIL preload_flags: got %b expected %b", Flags, 4'b1111);
        else passCount++;
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        checkCount++;
        if (Flags !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected %b", Flags, 4'b0000);
        else passCount++;
        checkCount++;
        if (CondEx !== 1'b0) $display("[TB] FAIL reset_condex: got %b expected %b", CondEx, 1'b0);
        else passCount++;
        checkCount++;
        if (PCWrite !== 1'b1) $display("[TB] FAIL reset_pcwrite: got %b expected %b", PCWrite, 1'b1);
        else passCount++;
        checkCount++;
        if (RegWrite !== 1'b0) $display("[TB] FAIL reset_regwrite: got %b expected %b", RegWrite, 1'b0);
        else passCount++;
        reset = 1'b0;
    endtask

    task automatic test_adds_beq();
        aluInstr(4'b1110, 2'b11, 4'b0100);
        checkCount++;
        if (Flags !== 4'b0100) $display("[TB] FAIL adds_flags: got %b expected %b", Flags, 4'b0100);
        else passCount++;
        fetchDecode(4'b0000);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkCount++;
        if (CondEx !== 1'b1) $display("[TB] FAIL beq_condex: got %b expected %b", CondEx, 1'b1);
        else passCount++;
        checkCount++;
        if (PCWrite !== 1'b1) $display("[TB] FAIL beq_pcwrite: got %b expected %b", PCWrite, 1'b1);
        else passCount++;
        tick();
    endtask

    task automatic test_not_taken();
        doReset();
        fetchDecode(4'b0000);
        applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkCount++;
        if (RegWrite !== 1'b0) $display("[TB] FAIL nt_regwrite: got %b expected %b", RegWrite, 1'b0);
        else passCount++;
        checkCount++;
        if (MemWrite !== 1'b0) $display("[TB] FAIL nt_memwrite: got %b expected %b", MemWrite, 1'b0);
        else passCount++;
        checkCount++;
        if (PCWrite !== 1'b0) $display("[TB] FAIL nt_pcwrite: got %b expected %b", PCWrite, 1'b0);
        else passCount++;
        tick();
        checkCount++;
        if (Flags !== 4'b0000) $display("[TB] FAIL nt_flags: got %b expected %b", Flags, 4'b0000);
        else passCount++;
    endtask

    task automatic test_partial_flags();
        aluInstr(4'b1110, 2'b10, 4'b1011);
        checkCount++;
        if (Flags !== 4'b1000) $display("[TB] FAIL partial_nz: got %b expected %b", Flags, 4'b1000);
        else passCount++;
        aluInstr(4'b1110, 2'b01, 4'b0110);
        checkCount++;
        if (Flags !== 4'b1010) $display("[TB] FAIL partial_cv: got %b expected %b", Flags, 4'b1010);
        else passCount++;
        aluInstr(4'b1110, 2'b11, 4'b1000);
    endtask

    task automatic test_cond_codes();
        logic [3:0] codes [8];
        logic       expect1 [8];
        codes   = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0100, 4'b0101, 4'b0000, 4'b0001};
        expect1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            fetchDecode(codes[i]);
            checkCount++;
            if (CondEx !== expect1[i]) $display("[TB] FAIL signed_cond_%b: got %b expected %b", codes[i], CondEx, expect1[i]);
            else passCount++;
        end
        aluInstr(4'b1110, 2'b11, 4'b0010);
        codes   = '{4'b1000, 4'b1001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1110, 4'b1100};
        expect1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            fetchDecode(codes[i]);
            checkCount++;
            if (CondEx !== expect1[i]) $display("[TB] FAIL unsigned_cond_%b: got %b expected %b", codes[i], CondEx, expect1[i]);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        fetchDecode(4'b1110);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (CondEx !== 1'b0) $display("[TB] FAIL overlap_condex: got %b expected %b", CondEx, 1'b0);
        else passCount++;
        checkCount++;
        if (Flags !== 4'b0100) $display("[TB] FAIL overlap_flags: got %b expected %b", Flags, 4'b0100);
        else passCount++;
        fetchDecode(4'b0000);
        checkCount++;
        if (CondEx !== 1'b1) $display("[TB] FAIL b2b_condex: got %b expected %b", CondEx, 1'b1);
        else passCount++;
    endtask

    task automatic test_irwrite_held();
        applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkCount++;
        if (CondEx !== 1'b0) $display("[TB] FAIL held_first: got %b expected %b", CondEx, 1'b0);
        else passCount++;
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (CondEx !== 1'b1) $display("[TB] FAIL held_last: got %b expected %b", CondEx, 1'b1);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkCount++;
        if (RegWrite !== 1'b1) $display("[TB] FAIL mid_pre_regwrite: got %b expected %b", RegWrite, 1'b1);
        else passCount++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkCount++;
        if (RegWrite !== 1'b0) $display("[TB] FAIL mid_regwrite: got %b expected %b", RegWrite, 1'b0);
        else passCount++;
        checkCount++;
        if (MemWrite !== 1'b0) $display("[TB] FAIL mid_memwrite: got %b expected %b", MemWrite, 1'b0);
        else passCount++;
    endtask

    task automatic test_nv();
        logic expNv;
`ifdef CONDLOGIC_NV_ALWAYS_EN
        expNv = 1'b1;
`else
        expNv = 1'b0;
`endif
        fetchDecode(4'b1111);
        applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkCount++;
        if (RegWrite !== expNv) $display("[TB] FAIL nv_regwrite: got %b expected %b", RegWrite, expNv);
        else passCount++;
        checkCount++;
        if (PCWrite !== 1'b1) $display("[TB] FAIL nv_pcwrite: got %b expected %b", PCWrite, 1'b1);
        else passCount++;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        test_reset();
        test_adds_beq();
        test_not_taken();
        test_partial_flags();
        test_cond_codes();
        test_back_to_back();
        test_irwrite_held();
        test_reset_mid();
        test_nv();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution stage of the multi-cycle ARM controller, directly downstream of `decode`. Holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field once per instruction. It gates `decode`'s raw write requests (PCS, RegW, MemW, FlagW) into the committed enables that drive the datapath: PCWrite, RegWrite, MemWrite and the flag registers.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `Cond` in 4: instruction condition field, Instr[31:28], taken from the instruction register.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU in the current cycle.
- `FlagW` in 2: from `decode`; bit1 requests an N,Z write, bit0 requests a C,V write.
- `PCS` in 1: from `decode`; branch or write to R15.
- `NextPC` in 1: from `decode`; unconditional PC increment (fetch).
- `RegW` in 1: from `decode`; raw register-write request.
- `MemW` in 1: from `decode`; raw memory-write request.
- `IRWrite` in 1: from `decode`; marks the fetch cycle.
- `PCWrite` out 1: committed PC write enable.
- `RegWrite` out 1: committed register-file write enable.
- `MemWrite` out 1: committed memory write enable.
- `Flags` out 4: current {N,Z,C,V} register value.
- `CondEx` out 1: registered condition result for the current instruction.

## Operation
- **Registers.**
  - `Flags[3:2]` (N,Z), `Flags[1:0]` (C,V).
  - `CondEx`.
  - `dec_cyc`: IRWrite delayed by one cycle, so it is 1 during the Decode cycle.
- **Condition evaluation** (combinational, against the current `Flags`):
  - EQ 0000: Z; NE 0001: !Z.
  - CS 0010: C; CC 0011: !C.
  - MI 0100: N; PL 0101: !N.
  - VS 0110: V; VC 0111: !V.
  - HI 1000: C & !Z; LS 1001: !C | Z.
  - GE 1010: N==V; LT 1011: N!=V.
  - GT 1100: !Z & (N==V); LE 1101: Z | (N!=V).
  - AL 1110: 1.
  - 1111: see Configuration.
- **CondEx capture.** Loads the evaluation result on the edge ending a cycle with `dec_cyc`=1. Otherwise it holds, so it stays stable through Execute, Memory and Writeback.
- **Output gating** (combinational):
  - `RegWrite` = RegW & CondEx.
  - `MemWrite` = MemW & CondEx.
  - `PCWrite` = (PCS & CondEx) | NextPC. NextPC is never gated.
- **Flag update.**
  - N,Z <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - C,V <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - The two halves are independent.
- **Reset values.** Flags=0000, CondEx=0, dec_cyc=0.
  - Consequence: RegWrite=MemWrite=0 and PCWrite=NextPC.

## Timing
- Condition-to-CondEx latency: one edge after the Decode cycle. CondEx is valid from the first Execute cycle.
- Flags visible on `Flags` the cycle after the write-enable cycle.
- **Simultaneous capture and flag write** (dec_cyc=1 while a gated FlagW is active): CondEx is evaluated on the pre-update flags. The new flags affect only the next instruction.
- **Back-to-back instructions.** The flag write in instruction N's ALU/writeback completes before instruction N+1's Decode cycle. N+1 therefore sees the updated flags, with no bypass required.
- **Reset mid-instruction.** All registers clear in the same edge. Any pending RegW/MemW/PCS is suppressed until the next Decode capture.
- **IRWrite held high on consecutive cycles.** dec_cyc follows it; CondEx re-captures each such cycle, and the last capture wins.

## Configuration
- `CONDLOGIC_NV_ALWAYS_EN` defined: Cond=1111 evaluates to 1 (unconditional).
- Undefined (default): Cond=1111 evaluates to 0 (never). The instruction executes no writes but fetch proceeds via NextPC.

## Structure
- **Shared package** (`arm_pkg`):
  - condition-code constants COND_EQ..COND_NV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- **Sub-module `condcheck`:** purely combinational (Cond, Flags) -> CondEx_next. All state (flag registers, CondEx, dec_cyc) stays in `condlogic`.

## Test plan
- **Reset.** Assert reset with Flags preloaded 1111 -> next cycle Flags=0000, CondEx=0; NextPC=1 gives PCWrite=1, RegW=1 gives RegWrite=0.
- **ADDS then BEQ.**
  - ADDS: FlagW=11, ALUFlags=0100, Cond=1110 -> Flags=0100.
  - Then Cond=0000 with PCS=1 -> CondEx=1 and PCWrite=1 in Execute.
- **Not-taken gating.** Flags=0000, Cond=0000 (EQ), RegW=1, MemW=1, FlagW=11 -> RegWrite=0, MemWrite=0, Flags unchanged at 0000.
- **Partial flag write.** Flags=0000, FlagW=10, ALUFlags=1011, CondEx=1 -> Flags=1000 (C,V untouched).
- **Signed and unsigned codes.**
  - Flags N=1,V=0: GE=0, LT=1, GT=0, LE=1.
  - Flags C=1,Z=0: HI=1, LS=0.
- **NV code.** Cond=1111, RegW=1 -> RegWrite=0 by default; RegWrite=1 with `CONDLOGIC_NV_ALWAYS_EN`.
